// File: rtl/sb_param_cfg_if.sv
// ---------------------------------------------------------------------------
// sb_param_cfg_if
//
// Purpose : configuration-chain bundle for the sb_param_cfg switch block.
//           Groups the serial bitstream, the shift/commit controls and the
//           status flags so a chain controller and the switch block can be
//           connected with one port.
//
// Signals :
//   ccff_head   master -> slave  serial configuration data in
//   cfg_en      master -> slave  shift enable, one bit per prog_clk cycle
//   cfg_commit  master -> slave  copy shadow selects into active selects
//   ccff_tail   slave -> master  serial data out (shadow register MSB)
//   cfg_full    slave -> master  shadow register holds a full fresh load
//   cfg_done    slave -> master  one-cycle pulse after an accepted commit
//   cfg_err     slave -> master  one-cycle pulse after a rejected commit
// ---------------------------------------------------------------------------
interface sb_param_cfg_if;

    logic ccff_head;
    logic cfg_en;
    logic cfg_commit;
    logic ccff_tail;
    logic cfg_full;
    logic cfg_done;
    logic cfg_err;

    modport master (
        output ccff_head,
        output cfg_en,
        output cfg_commit,
        input  ccff_tail,
        input  cfg_full,
        input  cfg_done,
        input  cfg_err
    );

    modport slave (
        input  ccff_head,
        input  cfg_en,
        input  cfg_commit,
        output ccff_tail,
        output cfg_full,
        output cfg_done,
        output cfg_err
    );

endinterface : sb_param_cfg_if

// File: rtl/sb_param_cfg.sv
// ---------------------------------------------------------------------------
// sb_param_cfg
//
// Purpose : parametrised switch block for the tile grid. W tracks leave on
//           the top side and W tracks on the right side; each output track
//           is a MUX_SIZE:1 routing mux. Mux selects are shifted serially
//           into a shadow register and only applied to the routing on an
//           explicit commit, so the routing never glitches while a bitstream
//           passes through the chain.
//
// Parameters :
//   W         tracks per side (2..64)
//   MUX_SIZE  inputs per routing mux (2, 4 or 8)
//
// Build option :
//   SB_CFG_PARITY_EN  when defined, the chain carries one extra odd-parity
//                     bit (the first bit shifted in, ending at the shadow
//                     MSB); a commit is accepted only if the XOR of the whole
//                     chain is 1. When undefined there is no parity bit and
//                     every commit from the full state is accepted.
//
// Ports :
//   prog_clk         configuration clock, the only clock
//   pReset           asynchronous active-low reset
//   cfg              sb_param_cfg_if.slave (chain data, shift/commit, flags)
//   chany_top_in     [W] top channel inputs
//   chanx_right_in   [W] right channel inputs
//   top_grid_pin     [W] grid pins feeding the top tracks
//   right_grid_pin   [W] grid pins feeding the right tracks
//   chany_top_out    [W] top channel outputs
//   chanx_right_out  [W] right channel outputs
// ---------------------------------------------------------------------------
module sb_param_cfg #(
    parameter int W        = 9,
    parameter int MUX_SIZE = 2
) (
    input  logic                 prog_clk,
    input  logic                 pReset,
    sb_param_cfg_if.slave        cfg,
    input  logic [W-1:0]         chany_top_in,
    input  logic [W-1:0]         chanx_right_in,
    input  logic [W-1:0]         top_grid_pin,
    input  logic [W-1:0]         right_grid_pin,
    output logic [W-1:0]         chany_top_out,
    output logic [W-1:0]         chanx_right_out
);

    localparam int SEL_BITS = $clog2(MUX_SIZE);
`ifdef SB_CFG_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int ACT_BITS = 2 * W * SEL_BITS;
    localparam int TOTAL    = ACT_BITS + PAR_BITS;
    localparam int CNT_W    = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_LOAD  = 2'd1,
        S_FULL  = 2'd2
    } state_e;

    logic [TOTAL-1:0]    sr_q,      sr_d;
    logic [ACT_BITS-1:0] act_q,     act_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    state_e              state_q,   state_d;
    logic                done_q,    done_d;
    logic                err_q,     err_d;
    logic                parity_ok;

`ifdef SB_CFG_PARITY_EN
    // Odd parity over the whole chain, parity bit included.
    assign parity_ok = ^sr_q;
`else
    assign parity_ok = 1'b1;
`endif

    // -----------------------------------------------------------------------
    // State register (holds every flop of the block)
    // -----------------------------------------------------------------------
    // NOTE: flops use non-blocking assignments and reset asynchronously, so
    // every register samples the same pre-edge values and pReset takes
    // effect immediately, aborting any shift or commit in progress.
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            sr_q      <= '0;
            act_q     <= '0;
            bit_cnt_q <= '0;
            state_q   <= S_EMPTY;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            act_q     <= act_d;
            bit_cnt_q <= bit_cnt_d;
            state_q   <= state_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a hold/idle default first so no path
        // through the branches below can leave one unassigned (no latches).
        sr_d      = sr_q;
        act_d     = act_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        if (cfg.cfg_commit) begin
            // Commit wins over a simultaneous shift enable.
            if ((state_q == S_FULL) && parity_ok) begin
                act_d     = sr_q[ACT_BITS-1:0];
                bit_cnt_d = '0;
                done_d    = 1'b1;
            end else begin
                err_d = 1'b1;
                // Only a parity failure from FULL discards the load; a
                // premature commit keeps the partial count.
                if (state_q == S_FULL) begin
                    bit_cnt_d = '0;
                end
            end
        end else if (cfg.cfg_en) begin
            sr_d = {sr_q[TOTAL-2:0], cfg.ccff_head};
            if (bit_cnt_q != CNT_FULL) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end

        // The state is a pure function of the bit count.
        if (bit_cnt_d == '0) begin
            state_d = S_EMPTY;
        end else if (bit_cnt_d == CNT_FULL) begin
            state_d = S_FULL;
        end else begin
            state_d = S_LOAD;
        end
    end

    // -----------------------------------------------------------------------
    // Output logic (all flags decode registered state only)
    // -----------------------------------------------------------------------
    always_comb begin
        cfg.cfg_full  = (state_q == S_FULL);
        cfg.ccff_tail = sr_q[TOTAL-1];
        cfg.cfg_done  = done_q;
        cfg.cfg_err   = err_q;
    end

    // -----------------------------------------------------------------------
    // Routing muxes: purely combinational from the active selects.
    // Mux m (0..W-1) drives top track m, mux W+i drives right track i.
    // Candidate indices are elaboration-time constants, so each track is a
    // plain MUX_SIZE:1 mux with no arithmetic in the data path.
    // -----------------------------------------------------------------------
    for (genvar i = 0; i < W; i++) begin : g_track
        logic [MUX_SIZE-1:0] top_cand;
        logic [MUX_SIZE-1:0] right_cand;

        assign top_cand[0]   = top_grid_pin[i];
        assign right_cand[0] = right_grid_pin[i];

        for (genvar k = 1; k < MUX_SIZE; k++) begin : g_src
            // Top track rotates forward through the right channel, right
            // track rotates backward through the top channel. The offset of
            // MUX_SIZE*W keeps the index non-negative when k exceeds i+W.
            assign top_cand[k]   = chanx_right_in[(i + k) % W];
            assign right_cand[k] = chany_top_in[(i + MUX_SIZE * W - k) % W];
        end

        assign chany_top_out[i]   = top_cand[act_q[i * SEL_BITS +: SEL_BITS]];
        assign chanx_right_out[i] = right_cand[act_q[(W + i) * SEL_BITS +: SEL_BITS]];
    end

endmodule : sb_param_cfg

// File: doc/sb_param_cfg.md
Name: sb_param_cfg

Overview:
- Parametrised switch block for the tile grid. It has W tracks on the top side and W tracks on the right side. Each output track is driven by a MUX_SIZE:1 routing mux.
- Mux selects are loaded serially through the configuration chain (ccff_head to ccff_tail) into a shadow shift register.
- Selects are applied to the routing only on an explicit commit. Routing therefore never glitches while a bitstream is being shifted through.
- Successor to the fixed 9-track, 2:1 corner switch block. Adds width and mux-size generics, a bit counter, a commit handshake and status flags.

Parameters:
- W, 9, tracks per side (2..64).
- MUX_SIZE, 2, inputs per routing mux; must be 2, 4 or 8.
- SEL_BITS, $clog2(MUX_SIZE), derived, select bits per mux.
- TOTAL, 2*W*SEL_BITS (+1 when SB_CFG_PARITY_EN is defined), derived, chain length in bits.

Ports:
- prog_clk  in  1  configuration clock; the only clock.
- pReset  in  1  asynchronous, active-low reset.
- ccff_head  in  1  serial configuration data in.
- cfg_en  in  1  shift enable; one bit per cycle.
- cfg_commit  in  1  request to copy shadow selects into active selects.
- chany_top_in  in  W  top channel inputs.
- chanx_right_in  in  W  right channel inputs.
- top_grid_pin  in  W  grid pins feeding the top tracks.
- right_grid_pin  in  W  grid pins feeding the right tracks.
- chany_top_out  out  W  top channel outputs.
- chanx_right_out  out  W  right channel outputs.
- ccff_tail  out  1  serial configuration data out (shadow register MSB).
- cfg_full  out  1  shadow register holds TOTAL fresh bits.
- cfg_done  out  1  one-cycle pulse after a successful commit.
- cfg_err  out  1  one-cycle pulse on a rejected commit.

Behaviour:
- Reset (pReset=0, asynchronous), all of the following cleared:
  - shadow shift register sr and active selects act
  - bit_cnt and state
  - cfg_full, cfg_done, cfg_err, ccff_tail
- After reset every mux selects input 0, so each track passes its grid pin. Reset asserted mid-shift or mid-commit aborts it immediately, with the same result.
- Shift: on a prog_clk rising edge with cfg_en=1 and cfg_commit=0:
  - sr <= {sr[TOTAL-2:0], ccff_head}
  - ccff_tail = sr[TOTAL-1], so bits daisy-chain to the next block with 1 cycle per bit.
  - bit_cnt increments and saturates at TOTAL.
  - Shifting continues past TOTAL as pass-through, so older bits fall out of ccff_tail.
- Mux m uses sr/act[m*SEL_BITS +: SEL_BITS]:
  - m = 0..W-1 drives top track m; m = W..2W-1 drives right track m-W.
  - The first bit shifted in ends at the MSB of mux 2W-1.
- Routing is purely combinational from act; no registers sit in the data path. Sources by select value k:
  - Top track i: k=0 selects top_grid_pin[i]; k>=1 selects chanx_right_in[(i+k)%W].
  - Right track i: k=0 selects right_grid_pin[i]; k>=1 selects chany_top_in[(i+W-k)%W].
- State machine, derived from bit_cnt:
  - EMPTY (bit_cnt=0) -> LOAD on the first shift.
  - LOAD -> FULL when bit_cnt reaches TOTAL.
  - cfg_full = (state==FULL), registered.
- Commit, sampled on a prog_clk edge:
  - In FULL (and parity ok when the option is enabled): act <= sr[2*W*SEL_BITS-1:0]; bit_cnt <= 0; state <= EMPTY; cfg_done=1 for the next cycle.
  - In EMPTY or LOAD: act is unchanged, bit_cnt is unchanged, cfg_err=1 for the next cycle.
- cfg_commit and cfg_en together: commit has priority and no shift occurs that cycle.
- Holding cfg_commit high:
  - A successful commit pulses cfg_done once.
  - Subsequent cycles are rejects, because state is then EMPTY.
- sr is not cleared by a commit, so re-committing requires a full reload.

Optional Feature:
- SB_CFG_PARITY_EN defined:
  - TOTAL includes one extra bit at sr[TOTAL-1]; it is the first bit shifted in.
  - A commit in FULL succeeds only when the XOR of all TOTAL bits is 1 (odd parity).
  - On mismatch: no update, cfg_err pulse, bit_cnt cleared to 0.
  - The parity bit is never applied to act.
- Not defined: no parity bit, and a commit in FULL always succeeds.

Test Plan:
- Reset, W=9, MUX_SIZE=2: drive top_grid_pin=9'h1A5 and right_grid_pin=9'h0F3 -> chany_top_out=9'h1A5, chanx_right_out=9'h0F3, cfg_full=0.
- Shift 18 ones and commit:
  - cfg_full goes 1 after the 18th shift; cfg_done pulses 1 cycle after the commit.
  - chany_top_out[i] = chanx_right_in[(i+1)%9]; chanx_right_out[0] = chany_top_in[8].
- Shift 10 bits then commit -> cfg_err pulses once; outputs unchanged; bit_cnt stays 10. Then 8 more shifts -> cfg_full=1.
- Shift 25 bits into an 18-bit chain:
  - The first 7 bits appear on ccff_tail on cycles 19..25.
  - A commit applies the last 18 bits.
- cfg_en and cfg_commit high together in FULL -> commit happens, sr is not shifted, cfg_done=1.
- W=4, MUX_SIZE=4, SB_CFG_PARITY_EN defined: 16 select bits all 1, plus parity bit 0 (even total) -> commit gives cfg_err; reload with parity bit 1 -> commit gives cfg_done and chany_top_out[0] = chanx_right_in[3].
